// File: rtl/mem32_acc.sv
// mem32_acc: byte-addressed master for the 32K x 32 single-port memory.
// Converts 1/2/4-byte accesses at any alignment into one or two word cycles
// with byte-lane masks, and right-justifies read data back to the core.
// Optional build macro: MEM32_SEXT_EN adds input sx (sign-extend narrow reads).
module mem32_acc #(
  parameter int ASZ = 15,
  parameter int DSZ = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req,
  input  logic           we,
  input  logic [1:0]     sz,
  input  logic [ASZ+1:0] addr,
  input  logic [DSZ-1:0] wdata,
  output logic           busy,
  output logic           ack,
  output logic [DSZ-1:0] rdata,
  output logic [ASZ-1:0] mem_ai,
  output logic           mem_we,
  output logic [3:0]     mem_bmsk,
  output logic [DSZ-1:0] mem_vi,
  input  logic [DSZ-1:0] mem_vo
`ifdef MEM32_SEXT_EN
  ,
  input  logic           sx
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_W0,
    S_W1,
    S_R0,
    S_R1,
    S_R2
  } state_t;

  state_t         state_q, state_d;
  logic           busy_q, busy_d;
  logic           ack_q, ack_d;
  logic [DSZ-1:0] rdata_q, rdata_d;
  logic [ASZ-1:0] mem_ai_q, mem_ai_d;
  logic           mem_we_q, mem_we_d;
  logic [3:0]     bmsk_q, bmsk_d;
  logic [DSZ-1:0] vi_q, vi_d;

  // Request context captured at accept
  logic [1:0]     sz_q, sz_d;
  logic [1:0]     o_q, o_d;
  logic           split_q, split_d;
  logic [ASZ-1:0] w1_q, w1_d;
  logic [3:0]     bm1_q, bm1_d;
  logic [DSZ-1:0] vi1_q, vi1_d;
  logic           sx_q, sx_d;
  logic [DSZ-1:0] lo_q, lo_d;

  logic           sx_in;
`ifdef MEM32_SEXT_EN
  assign sx_in = sx;
`else
  assign sx_in = 1'b0;
`endif

  // Request decode straight from the inputs (only used in the accept cycle)
  logic [1:0]       in_sz;
  logic [1:0]       in_o;
  logic [2:0]       in_nb;
  logic [3:0]       in_end;
  logic             in_split;
  logic [3:0]       in_m;
  logic [7:0]       in_bm2;
  logic [2*DSZ-1:0] in_vi2;
  logic [ASZ-1:0]   in_w0;

  // Lane mask and write data are shifted into a double-width field; the low
  // half feeds the first word and the high half the second word of a split.
  always_comb begin
    in_sz    = (sz == 2'd3) ? 2'd2 : sz;
    in_o     = addr[1:0];
    in_w0    = addr[ASZ+1:2];
    case (in_sz)
      2'd0:    begin in_nb = 3'd1; in_m = 4'b0001; end
      2'd1:    begin in_nb = 3'd2; in_m = 4'b0011; end
      default: begin in_nb = 3'd4; in_m = 4'b1111; end
    endcase
    in_end   = {2'b00, in_o} + {1'b0, in_nb};
    in_split = (in_end > 4'd4);
    in_bm2   = {4'b0000, in_m} << in_o;
    in_vi2   = {{DSZ{1'b0}}, wdata} << {in_o, 3'b000};
  end

  function automatic logic [DSZ-1:0] align_rd(input logic [2*DSZ-1:0] pair,
                                              input logic [1:0] o,
                                              input logic [1:0] s,
                                              input logic se);
    logic [2*DSZ-1:0] sh;
    logic [DSZ-1:0]   r;
    sh = pair >> {o, 3'b000};
    r  = sh[DSZ-1:0];
    case (s)
      2'd0:    align_rd = {{(DSZ-8){se & r[7]}}, r[7:0]};
      2'd1:    align_rd = {{(DSZ-16){se & r[15]}}, r[15:0]};
      default: align_rd = r;
    endcase
  endfunction

  // Next-state and registered-output computation
  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    ack_d    = 1'b0;
    rdata_d  = rdata_q;
    mem_ai_d = mem_ai_q;
    mem_we_d = 1'b0;
    bmsk_d   = bmsk_q;
    vi_d     = vi_q;
    sz_d     = sz_q;
    o_d      = o_q;
    split_d  = split_q;
    w1_d     = w1_q;
    bm1_d    = bm1_q;
    vi1_d    = vi1_q;
    sx_d     = sx_q;
    lo_d     = lo_q;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (req) begin
          busy_d   = 1'b1;
          sz_d     = in_sz;
          o_d      = in_o;
          split_d  = in_split;
          w1_d     = in_w0 + ASZ'(1);
          bm1_d    = in_bm2[7:4];
          vi1_d    = in_vi2[2*DSZ-1:DSZ];
          sx_d     = sx_in;
          mem_ai_d = in_w0;
          if (we) begin
            state_d  = S_W0;
            mem_we_d = 1'b1;
            bmsk_d   = in_bm2[3:0];
            vi_d     = in_vi2[DSZ-1:0];
          end else begin
            state_d  = S_R0;
            bmsk_d   = 4'b1111;
          end
        end
      end
      S_W0: begin
        if (split_q) begin
          state_d  = S_W1;
          mem_we_d = 1'b1;
          mem_ai_d = w1_q;
          bmsk_d   = bm1_q;
          vi_d     = vi1_q;
        end else begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          ack_d   = 1'b1;
        end
      end
      S_W1: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        ack_d   = 1'b1;
      end
      S_R0: begin
        state_d = S_R1;
        if (split_q) mem_ai_d = w1_q;
      end
      S_R1: begin
        lo_d = mem_vo;
        if (split_q) begin
          state_d = S_R2;
        end else begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          ack_d   = 1'b1;
          rdata_d = align_rd({{DSZ{1'b0}}, mem_vo}, o_q, sz_q, sx_q);
        end
      end
      S_R2: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        ack_d   = 1'b1;
        rdata_d = align_rd({mem_vo, lo_q}, o_q, sz_q, sx_q);
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      ack_q    <= 1'b0;
      rdata_q  <= '0;
      mem_ai_q <= '0;
      mem_we_q <= 1'b0;
      bmsk_q   <= 4'b0000;
      vi_q     <= '0;
      sz_q     <= '0;
      o_q      <= '0;
      split_q  <= 1'b0;
      w1_q     <= '0;
      bm1_q    <= '0;
      vi1_q    <= '0;
      sx_q     <= 1'b0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
      mem_ai_q <= mem_ai_d;
      mem_we_q <= mem_we_d;
      bmsk_q   <= bmsk_d;
      vi_q     <= vi_d;
      sz_q     <= sz_d;
      o_q      <= o_d;
      split_q  <= split_d;
      w1_q     <= w1_d;
      bm1_q    <= bm1_d;
      vi1_q    <= vi1_d;
      sx_q     <= sx_d;
      lo_q     <= lo_d;
    end
  end

  assign busy     = busy_q;
  assign ack      = ack_q;
  assign rdata    = rdata_q;
  assign mem_ai   = mem_ai_q;
  assign mem_we   = mem_we_q;
  assign mem_bmsk = bmsk_q;
  assign mem_vi   = vi_q;

endmodule

// File: tb/tb_mem32_acc.sv
// Testbench for mem32_acc with a behavioural model of the 32K x 32 memory.
module tb_mem32_acc;

`ifdef MEM32_SEXT_EN
  localparam bit SEXT = 1'b1;
`else
  localparam bit SEXT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  sz = 2'd0;
  logic [16:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        sx = 1'b0;
  logic        busy, ack, mem_we;
  logic [31:0] rdata, mem_vi;
  logic [31:0] mem_vo = '0;
  logic [14:0] mem_ai;
  logic [3:0]  mem_bmsk;
  logic        mem_clr = 1'b1;

  logic [31:0] mem [0:32767];

  int checks = 0;
  int failures = 0;

  mem32_acc #(.ASZ(15), .DSZ(32)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .sz(sz), .addr(addr),
    .wdata(wdata), .busy(busy), .ack(ack), .rdata(rdata),
    .mem_ai(mem_ai), .mem_we(mem_we), .mem_bmsk(mem_bmsk),
    .mem_vi(mem_vi), .mem_vo(mem_vo)
`ifdef MEM32_SEXT_EN
    , .sx(sx)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous single-port memory: masked write, read data one cycle later
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 32768; i++) mem[i] <= '0;
    end else begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_bmsk[b]) mem[mem_ai][8*b +: 8] <= mem_vi[8*b +: 8];
      end
      mem_vo <= mem[mem_ai];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic [16:0] addr;
    logic [31:0] wdata;
    logic        sx;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  function automatic vec_t mk(input logic w, input logic [1:0] s, input logic [16:0] a,
                              input logic [31:0] d, input logic x, input logic [31:0] e,
                              input int l);
    vec_t v;
    v.we = w; v.sz = s; v.addr = a; v.wdata = d; v.sx = x; v.exp = e; v.lat = l;
    return v;
  endfunction

  // One transaction: returns ack latency (0 on timeout), read data, busy sanity
  task automatic txn(input logic twe, input logic [1:0] tsz, input logic [16:0] taddr,
                     input logic [31:0] twd, input logic tsx,
                     output logic [31:0] rd, output int lat, output logic busy_ok);
    @(negedge clk);
    req = 1'b1; we = twe; sz = tsz; addr = taddr; wdata = twd; sx = tsx;
    lat = 0; rd = '0; busy_ok = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      req = 1'b0;
      if (ack) begin
        lat = k; rd = rdata;
        if (busy) busy_ok = 1'b0;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
  endtask

  vec_t        vq[$];
  logic [31:0] rd;
  int          lat;
  logic        bok;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_ack", ack, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_ai", mem_ai, 0);
    check("rst_bmsk", mem_bmsk, 0);
    check("rst_mem_vi", mem_vi, 0);
    check("rst_rdata", rdata, 0);
    rst = 1'b0; mem_clr = 1'b0;

    // Split half write across the top of memory, wrapping to word 0
    @(negedge clk);
    req = 1'b1; we = 1'b1; sz = 2'd1; addr = 17'h1FFFF; wdata = 32'h0000BEEF;
    @(negedge clk); req = 1'b0;
    check("hw_c1_we", mem_we, 1);
    check("hw_c1_ai", mem_ai, 32'h7FFF);
    check("hw_c1_bmsk", mem_bmsk, 4'b1000);
    check("hw_c1_vi", mem_vi, 32'hEF000000);
    check("hw_c1_busy", busy, 1);
    @(negedge clk);
    check("hw_c2_we", mem_we, 1);
    check("hw_c2_ai", mem_ai, 0);
    check("hw_c2_bmsk", mem_bmsk, 4'b0001);
    check("hw_c2_vi", mem_vi, 32'h000000BE);
    check("hw_c2_ack", ack, 0);
    @(negedge clk);
    check("hw_c3_ack", ack, 1);
    check("hw_c3_busy", busy, 0);
    check("hw_c3_we", mem_we, 0);

    // Directed vectors; memory state carries from one entry to the next
    vq.push_back(mk(0, 2'd1, 17'h1FFFF, 0, 0, 32'h0000BEEF, 4));
    vq.push_back(mk(1, 2'd2, 17'h00000, 32'h11223344, 0, 0, 2));
    vq.push_back(mk(0, 2'd2, 17'h00000, 0, 0, 32'h11223344, 3));
    vq.push_back(mk(1, 2'd2, 17'h00002, 32'hDDCCBBAA, 0, 0, 3));
    vq.push_back(mk(0, 2'd2, 17'h00002, 0, 0, 32'hDDCCBBAA, 4));
    vq.push_back(mk(0, 2'd0, 17'h00001, 0, 0, 32'h00000033, 3));
    vq.push_back(mk(1, 2'd0, 17'h00007, 32'h00000080, 0, 0, 2));
    vq.push_back(mk(0, 2'd0, 17'h00007, 0, 1, SEXT ? 32'hFFFFFF80 : 32'h00000080, 3));
    vq.push_back(mk(0, 2'd2, 17'h00004, 0, 0, 32'h8000DDCC, 3));
    vq.push_back(mk(0, 2'd1, 17'h00005, 0, 1, 32'h000000DD, 3));
    vq.push_back(mk(0, 2'd3, 17'h00003, 0, 0, 32'h00DDCCBB, 4));
    vq.push_back(mk(1, 2'd1, 17'h00003, 32'h00001234, 0, 0, 3));
    vq.push_back(mk(0, 2'd2, 17'h00000, 0, 0, 32'h34AA3344, 3));
    vq.push_back(mk(0, 2'd2, 17'h00004, 0, 0, 32'h8000DD12, 3));
    vq.push_back(mk(0, 2'd1, 17'h00002, 0, 0, 32'h000034AA, 3));
    vq.push_back(mk(0, 2'd1, 17'h00006, 0, 1, SEXT ? 32'hFFFF8000 : 32'h00008000, 3));
    vq.push_back(mk(0, 2'd1, 17'h00006, 0, 0, 32'h00008000, 3));
    foreach (vq[i]) begin
      txn(vq[i].we, vq[i].sz, vq[i].addr, vq[i].wdata, vq[i].sx, rd, lat, bok);
      check($sformatf("vec%0d_lat", i), lat, vq[i].lat);
      check($sformatf("vec%0d_busy", i), {31'b0, bok}, 1);
      if (!vq[i].we) check($sformatf("vec%0d_rdata", i), rd, vq[i].exp);
    end

    // req held high through a split read: second accept only in the ack cycle
    @(negedge clk);
    req = 1'b1; we = 1'b0; sz = 2'd2; addr = 17'h00002;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check($sformatf("b2b_ack%0d", k), ack, (k == 4 || k == 8) ? 1 : 0);
      check($sformatf("b2b_busy%0d", k), busy, (k == 4 || k == 8) ? 0 : 1);
      check($sformatf("b2b_ai%0d", k), mem_ai, (k == 1 || k == 5) ? 0 : 1);
      if (k == 4 || k == 8) check($sformatf("b2b_rdata%0d", k), rdata, 32'hDD1234AA);
      if (k == 8) req = 1'b0;
    end
    @(negedge clk);
    check("b2b_no_third_busy", busy, 0);
    check("b2b_no_third_ack", ack, 0);

    // Reset lands while the second word of a split write is still pending
    @(negedge clk);
    req = 1'b1; we = 1'b1; sz = 2'd2; addr = 17'h00006; wdata = 32'hCAFEF00D;
    @(negedge clk); req = 1'b0;
    check("rstw_c1_we", mem_we, 1);
    check("rstw_c1_ai", mem_ai, 1);
    check("rstw_c1_bmsk", mem_bmsk, 4'b1100);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("rstw_c2_we", mem_we, 0);
    check("rstw_c2_ack", ack, 0);
    check("rstw_c2_busy", busy, 0);
    @(negedge clk);
    check("rstw_c3_ack", ack, 0);
    check("rstw_c3_we", mem_we, 0);
    txn(1'b0, 2'd2, 17'h00008, 0, 1'b0, rd, lat, bok);
    check("rstw_word2_lat", lat, 3);
    check("rstw_word2", rd, 32'h00000000);
    txn(1'b0, 2'd2, 17'h00004, 0, 1'b0, rd, lat, bok);
    check("rstw_word1", rd, 32'hF00DDD12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
